// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_master_pkg;

   // Frame phases: IDLE -> START -> SEND -> [WAIT] -> [RECV] -> END -> IDLE
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_SEND  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RECV  = 3'd4,
      ST_END   = 3'd5
   } spi_mst_state_t;

   // Command opcodes carried in req_data[9:8]
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   // Select bit plus the 10-bit command go out on MOSI; 8 bits come back on MISO
   localparam int SEND_BITS = 11;
   localparam int RECV_BITS = 8;

endpackage

// File: rtl/spi_mst_shreg.sv
// Transmit and receive shift registers for the SPI master.
// The tx register holds {select bit, command} and shifts out MSB first;
// the rx register collects MISO so the first sample ends up in the MSB.
module spi_mst_shreg #(
   parameter int CMD_W  = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [CMD_W-1:0]  cmd_i,
   input  logic              tx_shift_i,
   input  logic              rx_shift_i,
   input  logic              miso_i,
   output logic              tx_bit_o,
   output logic [DATA_W-1:0] rx_next_o
);

   localparam int TX_W = CMD_W + 1;

   logic [TX_W-1:0]   tx_q, tx_d;
   // Only DATA_W-1 bits are stored: the last sample is taken straight from MISO
   logic [DATA_W-2:0] rx_q, rx_d;

   assign tx_bit_o  = tx_q[TX_W-1];
   assign rx_next_o = {rx_q, miso_i};

   // Next-state for both shift registers; load has priority over shift
   always_comb begin
      tx_d = tx_q;
      rx_d = rx_q;
      if (load_i) begin
         tx_d = {cmd_i[CMD_W-1], cmd_i};
      end else if (tx_shift_i) begin
         tx_d = {tx_q[TX_W-2:0], 1'b0};
      end
      if (rx_shift_i) begin
         rx_d = rx_next_o[DATA_W-2:0];
      end
   end

   // Shift register state, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q <= '0;
         rx_q <= '0;
      end else begin
         tx_q <= tx_d;
         rx_q <= rx_d;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: accepts 10-bit commands, serialises them on MOSI
// under SS_n (shared system clock, no SCLK), and for read-data commands
// captures 8 MISO bits after a fixed slave turnaround.
//
// Request handshake: a command transfers on a rising edge where both
// req_valid and req_ready are high. req_ready is high only in IDLE and
// never during rst; the producer holds req_valid/req_data until accepted.
module spi_master_ctrl
   import spi_master_pkg::*;
#(
   parameter int CMD_W   = 10,
   parameter int DATA_W  = 8,
   parameter int RD_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CMD_W-1:0]  req_data,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam logic [3:0] SEND_LAST = 4'(SEND_BITS - 1);
   localparam logic [3:0] RECV_LAST = 4'(RECV_BITS - 1);
   localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

   spi_mst_state_t    state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              rd_frame_q, rd_frame_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;

   logic              accept;
   logic              sr_load;
   logic              sr_tx_shift;
   logic              sr_rx_shift;
   logic              sr_tx_bit;
   logic [DATA_W-1:0] sr_rx_next;

   assign busy      = (state_q != ST_IDLE);
   assign req_ready = !busy && !rst;
   assign accept    = req_valid && req_ready;
   assign resp_data = resp_data_q;

   spi_mst_shreg #(
      .CMD_W  (CMD_W),
      .DATA_W (DATA_W)
   ) u_shreg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (sr_load),
      .cmd_i      (req_data),
      .tx_shift_i (sr_tx_shift),
      .rx_shift_i (sr_rx_shift),
      .miso_i     (MISO),
      .tx_bit_o   (sr_tx_bit),
      .rx_next_o  (sr_rx_next)
   );

   // Next-state, counter and output decode for the frame sequencer
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      rd_frame_d  = rd_frame_q;
      resp_data_d = resp_data_q;
      sr_load     = 1'b0;
      sr_tx_shift = 1'b0;
      sr_rx_shift = 1'b0;
      SS_n        = 1'b1;
      MOSI        = 1'b0;
      resp_valid  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               sr_load    = 1'b1;
               rd_frame_d = (req_data[CMD_W-1 -: 2] == OP_RD_DATA);
               bit_cnt_d  = '0;
               wait_cnt_d = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            SS_n    = 1'b0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            SS_n        = 1'b0;
            MOSI        = sr_tx_bit;
            sr_tx_shift = 1'b1;
            if (bit_cnt_q == SEND_LAST) begin
               bit_cnt_d = '0;
               if (!rd_frame_q) begin
                  state_d = ST_END;
               end else if (RD_WAIT == 0) begin
                  state_d = ST_RECV;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_WAIT: begin
            SS_n = 1'b0;
            if (wait_cnt_q == WAIT_LAST) begin
               wait_cnt_d = '0;
               state_d    = ST_RECV;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         ST_RECV: begin
            SS_n        = 1'b0;
            sr_rx_shift = 1'b1;
            if (bit_cnt_q == RECV_LAST) begin
               bit_cnt_d   = '0;
               resp_data_d = sr_rx_next;
               state_d     = ST_END;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_END: begin
            resp_valid = rd_frame_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // While reset is held the bus looks idle regardless of the old state
      if (rst) begin
         SS_n       = 1'b1;
         MOSI       = 1'b0;
         resp_valid = 1'b0;
      end
   end

   // Sequencer state, counters and the held response byte
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         rd_frame_q  <= 1'b0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         rd_frame_q  <= rd_frame_d;
         resp_data_q <= resp_data_d;
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave + RAM model
// and an expected-response queue for read-data frames.
module tb_spi_master_ctrl;

   localparam int CMD_W   = 10;
   localparam int DATA_W  = 8;
   localparam int RD_WAIT = 2;

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              req_valid = 1'b0;
   logic [CMD_W-1:0]  req_data  = '0;
   logic              MISO      = 1'b0;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic              busy;
   logic              SS_n;
   logic              MOSI;

   spi_master_ctrl #(
      .CMD_W   (CMD_W),
      .DATA_W  (DATA_W),
      .RD_WAIT (RD_WAIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .busy       (busy),
      .SS_n       (SS_n),
      .MOSI       (MOSI),
      .MISO       (MISO)
   );

   // Scoreboard state
   int n_cmp = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [7:0] last_resp;

   // Intent-level model (from commands as driven) and slave model (from MOSI as seen)
   logic [7:0] exp_ram [256];
   logic [7:0] slv_ram [256];
   logic [7:0] exp_wptr, exp_rptr, slv_wptr, slv_rptr;

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk10(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected behaviour of the slave RAM, applied when a command is driven
   task automatic model_cmd(input logic [9:0] cmd);
      case (cmd[9:8])
         2'b00:   exp_wptr = cmd[7:0];
         2'b01:   exp_ram[exp_wptr] = cmd[7:0];
         2'b10:   exp_rptr = cmd[7:0];
         default: exp_q.push_back(exp_ram[exp_rptr]);
      endcase
   endtask

   // Slave side: act on the command reconstructed from MOSI
   task automatic slave_cmd(input logic [9:0] cmd, output logic [7:0] rd_byte);
      rd_byte = slv_ram[slv_rptr];
      case (cmd[9:8])
         2'b00:   slv_wptr = cmd[7:0];
         2'b01:   slv_ram[slv_wptr] = cmd[7:0];
         2'b10:   slv_rptr = cmd[7:0];
         default: rd_byte = slv_ram[slv_rptr];
      endcase
   endtask

   // Drive one command and check the frame cycle by cycle up to and including END.
   // Called at a falling edge; returns at the falling edge inside the END cycle.
   task automatic run_frame(input logic [9:0] cmd, input bit keep_valid, output int waited);
      logic [10:0] tx;
      logic [9:0]  rx_cmd;
      logic [7:0]  slv_byte;
      logic [7:0]  r_exp;
      logic        is_rd;
      int          len;
      tx       = {cmd[9], cmd};
      is_rd    = (cmd[9:8] == 2'b11);
      len      = is_rd ? (22 + RD_WAIT) : 14;
      rx_cmd   = '0;
      slv_byte = '0;
      waited   = 0;
      req_valid = 1'b1;
      req_data  = cmd;
      while (!req_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_err++;
         $error("FAIL accept_timeout cmd=%0h got req_ready=0 exp req_ready=1", cmd);
         req_valid = 1'b0;
         return;
      end
      model_cmd(cmd);
      for (int k = 1; k < len; k++) begin
         @(negedge clk);
         if (k == 1 && !keep_valid) req_valid = 1'b0;
         chk1("ss_n", SS_n, (k == len - 1));
         chk1("mosi", MOSI, (k >= 2 && k <= 12) ? tx[12 - k] : 1'b0);
         chk1("busy", busy, 1'b1);
         chk1("req_ready_busy", req_ready, 1'b0);
         chk1("resp_valid", resp_valid, is_rd && (k == len - 1));
         if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $error("FAIL resp_unexpected got=%0h exp=none", resp_data);
            end else begin
               r_exp = exp_q.pop_front();
               chk8("resp_data", resp_data, r_exp);
               last_resp = r_exp;
            end
         end
         if (k >= 3 && k <= 12) rx_cmd = {rx_cmd[8:0], MOSI};
         if (k == 12) begin
            chk10("slave_cmd", rx_cmd, cmd);
            slave_cmd(rx_cmd, slv_byte);
         end
         if (is_rd && k >= 13 + RD_WAIT && k <= 20 + RD_WAIT) begin
            MISO = slv_byte[20 + RD_WAIT - k];
         end else begin
            MISO = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // One cycle after END: back in IDLE with the response byte held
   task automatic idle_check();
      @(negedge clk);
      chk1("idle_ss_n", SS_n, 1'b1);
      chk1("idle_mosi", MOSI, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_req_ready", req_ready, 1'b1);
      chk1("idle_resp_valid", resp_valid, 1'b0);
      chk8("idle_resp_hold", resp_data, last_resp);
   endtask

   // Watchdog
   initial begin
      #200000;
      $error("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Directed sequence
   initial begin
      int w;
      logic [9:0] b2b [3];
      logic [9:0] rc;
      for (int i = 0; i < 256; i++) begin
         exp_ram[i] = '0;
         slv_ram[i] = '0;
      end
      exp_wptr = '0; exp_rptr = '0; slv_wptr = '0; slv_rptr = '0;
      last_resp = '0;

      // Power-on reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk1("rst_ss_n", SS_n, 1'b1);
      chk1("rst_mosi", MOSI, 1'b0);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_resp_data", resp_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk1("post_rst_ready", req_ready, 1'b1);

      // Write-addr, rd-addr, rd-data returning C3
      run_frame(10'b00_1010_0101, 1'b0, w);
      idle_check();
      run_frame(10'b10_0000_1111, 1'b0, w);
      idle_check();
      exp_ram[8'h0F] = 8'hC3;
      slv_ram[8'h0F] = 8'hC3;
      run_frame(10'b11_0000_0000, 1'b0, w);
      idle_check();
      chk8("rd_c3_held", resp_data, 8'hC3);

      // Back-to-back with req_valid held high
      b2b[0] = 10'b00_0100_0000;
      b2b[1] = 10'b01_1001_1001;
      b2b[2] = 10'b00_0100_0001;
      for (int j = 0; j < 3; j++) begin
         run_frame(b2b[j], 1'b1, w);
         if (j > 0) chk8("b2b_gap", 8'(w), 8'd1);
      end
      req_valid = 1'b0;
      idle_check();

      // End-to-end through the slave RAM
      run_frame(10'b00_0001_0010, 1'b0, w); idle_check();
      run_frame(10'b01_0101_1010, 1'b0, w); idle_check();
      run_frame(10'b10_0001_0010, 1'b0, w); idle_check();
      run_frame(10'b11_1111_0000, 1'b0, w); idle_check();
      chk8("e2e_5a", resp_data, 8'h5A);
      run_frame(10'b10_0100_0000, 1'b0, w); idle_check();
      run_frame(10'b11_0000_0001, 1'b0, w); idle_check();
      chk8("b2b_readback_99", resp_data, 8'h99);

      // Random commands
      for (int j = 0; j < 8; j++) begin
         rc = 10'($urandom_range(0, 1023));
         run_frame(rc, 1'b0, w);
         idle_check();
      end

      // Reset for 3 cycles in the middle of SEND
      req_valid = 1'b1;
      req_data  = 10'b10_1010_1011;
      chk1("mid_rst_accept", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk1("mid_rst_pre_ss_n", SS_n, 1'b0);
      rst = 1'b1;
      last_resp = '0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk1("mid_rst_ss_n", SS_n, 1'b1);
         chk1("mid_rst_mosi", MOSI, 1'b0);
         chk1("mid_rst_resp_valid", resp_valid, 1'b0);
         chk1("mid_rst_ready", req_ready, 1'b0);
         chk1("mid_rst_busy", busy, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk1("after_rst_ready", req_ready, 1'b1);
      chk1("after_rst_ss_n", SS_n, 1'b1);
      chk1("after_rst_mosi", MOSI, 1'b0);
      chk8("after_rst_resp_data", resp_data, 8'h00);

      // Normal traffic resumes after the abandoned frame
      run_frame(10'b10_0001_0010, 1'b0, w); idle_check();
      run_frame(10'b11_0000_0000, 1'b0, w); idle_check();
      chk8("after_rst_read_5a", resp_data, 8'h5A);

      chk8("exp_q_drained", 8'(exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Bus-side SPI master that drives the SPI-slave/single-port-RAM wrapper, sitting directly upstream of it.
- Takes 10-bit command words from a valid/ready request interface.
- Serialises each command onto MOSI under SS_n, MSB first, on the shared system clock (no separate SCLK).
- For read-data commands, waits for the slave's turnaround, captures 8 MISO bits and returns them on a one-cycle response strobe.

Parameters:
CMD_W, 10, command word width (2 opcode bits + 8 payload bits)
DATA_W, 8, read-data width captured from MISO
RD_WAIT, 2, idle cycles between last command bit and first MISO sample (slave RAM + tx turnaround); legal 0..15

Ports:
clk  input  1  system clock, shared with the slave; all logic on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  command word available
req_ready  output  1  master idle, can accept a command
req_data  input  CMD_W  command: [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload
resp_valid  output  1  one-cycle strobe, read data valid
resp_data  output  DATA_W  captured read byte; holds value until next capture
busy  output  1  frame in progress (state != IDLE)
SS_n  output  1  slave select, active low
MOSI  output  1  serial data to slave
MISO  input  1  serial data from slave

Behaviour:
- One clock: clk. Reset rst is synchronous, active-high.
- Reset values: SS_n=1, MOSI=0, req_ready=0 during rst (1 from the first cycle after), resp_valid=0, resp_data=0, busy=0, state IDLE, counters 0.
- States: IDLE, START, SEND, WAIT, RECV, END.
- IDLE: req_ready=1, SS_n=1. On req_valid&&req_ready at edge T, latch req_data into shift register and go to START.
- START (cycle T+1): SS_n=0, MOSI=0.
- SEND (T+2..T+12, 11 cycles):
  - MOSI bit 0 = req_data[9] (slave write/read select).
  - Then req_data[9:0] MSB first.
  - bit_cnt counts 0..10.
  - On exit: opcode 11 -> WAIT; otherwise -> END.
- WAIT: SS_n=0, MOSI=0 for RD_WAIT cycles, then RECV. With RD_WAIT=0, go directly to RECV.
- RECV: 8 cycles, SS_n=0. Each rising edge shifts MISO into rx_shreg LSB, so the first sample lands in resp_data[7]. Then END.
- END: SS_n=1, MOSI=0 for exactly one cycle, then IDLE.
  - For read-data frames: resp_data updated and resp_valid=1 during the END cycle only.
  - req_ready returns at the cycle after END.
- Frame lengths, accept edge to next req_ready=1:
  - Write / rd-addr: 14 cycles.
  - Rd-data: 22+RD_WAIT cycles.
- req_valid while busy is ignored; the request is held by the producer (standard valid/ready, no drop).
- MISO is ignored outside RECV.
- SS_n never glitches high mid-frame. SS_n is high for at least 2 cycles between frames (END plus IDLE).
- rst asserted mid-frame: next edge forces IDLE, SS_n=1, no resp_valid; the partial frame is abandoned.
- busy = (state != IDLE). req_ready = !busy && !rst.

Decomposition:
- Package spi_master_pkg:
  - state enum type spi_mst_state_t.
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - SEND_BITS=11, RECV_BITS=8.
- Sub-module spi_mst_shreg: a natural split holding the tx (11-bit) and rx (8-bit) shift registers plus load/shift enables. FSM and counters stay in spi_master_ctrl.

Test Plan:
- Reset: hold rst 3 cycles mid-SEND -> SS_n=1, MOSI=0, resp_valid=0, req_ready=1 on first cycle after rst drops.
- Write-addr 10'b00_1010_0101 -> SS_n low T+1..T+12, MOSI sequence 0,0,0,1,0,1,0,0,1,0,1, SS_n=1 at T+13, req_ready=1 at T+14, no resp_valid.
- Rd-addr 10'b10_0000_1111 -> first MOSI bit 1, 14-cycle frame, no resp_valid.
- Rd-data 10'b11_0000_0000 with slave returning 8'hC3, RD_WAIT=2 -> WAIT 2 cycles, RECV 8 cycles, resp_valid one cycle with resp_data=8'hC3, frame length 24.
- Back-to-back: req_valid held high with 3 queued writes -> each accepted only when req_ready=1, SS_n high at least 2 cycles between frames, no lost or duplicated command.
- End-to-end with slave+RAM: wr-addr 0x12, wr-data 0x5A, rd-addr 0x12, rd-data -> resp_data=8'h5A.
